// File: rtl/param_memory.sv
// Parameterised single-port word memory with per-byte write enables,
// self-zeroing after reset and on request, and a 1- or 2-cycle read pipeline.
module param_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    CS,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    busy
);

  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    READY = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [ADDR_WIDTH-1:0]   cnt_nxt;
  logic                    zero_we;
  logic                    acc;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  assign busy   = (state != READY);
  // clear has priority over an access presented in the same cycle
  assign acc    = (state == READY) && CS && !clear;
  assign wr_acc = acc && wr_en;
  assign rd_acc = acc && !wr_en;

  // State and zeroing-counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: INIT/CLEAR sweep every address once, then go READY
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    zero_we   = 1'b0;
    case (state)
      INIT, CLEAR: begin
        zero_we = 1'b1;
        if (cnt == '1) begin
          state_nxt = READY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      READY: begin
        if (clear) state_nxt = CLEAR;
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Memory array: zeroing sweep or byte-masked write
  always_ff @(posedge clk) begin
    if (zero_we) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (byte_en[b]) mem[addr_in][8*b +: 8] <= data_in[8*b +: 8];
      end
    end
  end

  // First read stage; data register holds zero whenever no read was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_acc;
      rd_data_q  <= rd_acc ? mem[addr_in] : '0;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  rd_valid_q2;
      logic [DATA_WIDTH-1:0] rd_data_q2;

      // Optional second read stage for an extra cycle of latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid_q2 <= 1'b0;
          rd_data_q2  <= '0;
        end else begin
          rd_valid_q2 <= rd_valid_q;
          rd_data_q2  <= rd_data_q;
        end
      end

      assign rd_valid = rd_valid_q2;
      assign data_out = rd_data_q2;
    end else begin : g_no_out_reg
      assign rd_valid = rd_valid_q;
      assign data_out = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_memory.sv
// Directed bench: two instances (latency 1 and latency 2) share all inputs.
module tb_param_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        CS;
  logic        wr_en;
  logic [3:0]  byte_en;
  logic [3:0]  addr_in;
  logic [31:0] data_in;
  logic        clear;
  logic [31:0] data_out0, data_out1;
  logic        rd_valid0, rd_valid1;
  logic        busy0, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .CS(CS), .wr_en(wr_en), .byte_en(byte_en),
    .addr_in(addr_in), .data_in(data_in), .clear(clear),
    .data_out(data_out0), .rd_valid(rd_valid0), .busy(busy0)
  );

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .CS(CS), .wr_en(wr_en), .byte_en(byte_en),
    .addr_in(addr_in), .data_in(data_in), .clear(clear),
    .data_out(data_out1), .rd_valid(rd_valid1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CS = 1'b0; wr_en = 1'b0; byte_en = 4'h0; addr_in = 4'h0; data_in = '0; clear = 1'b0;
  endtask

  task automatic set_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    CS = 1'b1; wr_en = 1'b1; addr_in = a; data_in = d; byte_en = be; clear = 1'b0;
  endtask

  task automatic set_rd(input logic [3:0] a);
    CS = 1'b1; wr_en = 1'b0; addr_in = a; byte_en = 4'h0; data_in = '0; clear = 1'b0;
  endtask

  // After a release of rst_n just past an edge, busy must stay high for 16 edges
  task automatic check_sweep(input string tag);
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("%s_busy0_k%0d", tag, k), {31'd0, busy0}, (k < 16) ? 32'd1 : 32'd0);
      check($sformatf("%s_busy1_k%0d", tag, k), {31'd0, busy1}, (k < 16) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    // reset state
    check("rst_busy0", {31'd0, busy0}, 32'd1);
    check("rst_busy1", {31'd0, busy1}, 32'd1);
    check("rst_valid0", {31'd0, rd_valid0}, 32'd0);
    check("rst_valid1", {31'd0, rd_valid1}, 32'd0);
    check("rst_dout0", data_out0, 32'd0);
    check("rst_dout1", data_out1, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    check_sweep("init");

    // read of a freshly zeroed word
    set_rd(4'd7);
    tick();
    idle();
    check("rd7_valid0", {31'd0, rd_valid0}, 32'd1);
    check("rd7_dout0", data_out0, 32'd0);
    check("rd7_valid1_early", {31'd0, rd_valid1}, 32'd0);
    tick();
    check("rd7_valid0_off", {31'd0, rd_valid0}, 32'd0);
    check("rd7_valid1", {31'd0, rd_valid1}, 32'd1);
    check("rd7_dout1", data_out1, 32'd0);

    // byte-masked write then read on the next cycle
    set_wr(4'd3, 32'hAABBCCDD, 4'b1111);
    tick();
    set_wr(4'd3, 32'h11223344, 4'b0101);
    tick();
    set_rd(4'd3);
    tick();
    idle();
    check("be_valid0", {31'd0, rd_valid0}, 32'd1);
    check("be_dout0", data_out0, 32'hAA22CC44);
    tick();
    check("be_valid1", {31'd0, rd_valid1}, 32'd1);
    check("be_dout1", data_out1, 32'hAA22CC44);
    check("be_dout0_idle", data_out0, 32'd0);

    // all-zero byte_en is a no-op write
    set_wr(4'd3, 32'hFFFFFFFF, 4'b0000);
    tick();
    set_rd(4'd3);
    tick();
    idle();
    check("noop_dout0", data_out0, 32'hAA22CC44);
    tick();

    // back-to-back reads of 0,1,2
    set_wr(4'd0, 32'h10, 4'hF); tick();
    set_wr(4'd1, 32'h20, 4'hF); tick();
    set_wr(4'd2, 32'h30, 4'hF); tick();
    set_rd(4'd0); tick();
    check("b2b_r0_v0", {31'd0, rd_valid0}, 32'd1);
    check("b2b_r0_d0", data_out0, 32'h10);
    check("b2b_r0_v1", {31'd0, rd_valid1}, 32'd0);
    check("b2b_r0_d1", data_out1, 32'd0);
    set_rd(4'd1); tick();
    check("b2b_r1_d0", data_out0, 32'h20);
    check("b2b_r1_v1", {31'd0, rd_valid1}, 32'd1);
    check("b2b_r1_d1", data_out1, 32'h10);
    set_rd(4'd2); tick();
    idle();
    check("b2b_r2_d0", data_out0, 32'h30);
    check("b2b_r2_v1", {31'd0, rd_valid1}, 32'd1);
    check("b2b_r2_d1", data_out1, 32'h20);
    tick();
    check("b2b_r3_v0", {31'd0, rd_valid0}, 32'd0);
    check("b2b_r3_d0", data_out0, 32'd0);
    check("b2b_r3_v1", {31'd0, rd_valid1}, 32'd1);
    check("b2b_r3_d1", data_out1, 32'h30);
    tick();
    check("b2b_r4_v1", {31'd0, rd_valid1}, 32'd0);
    check("b2b_r4_d1", data_out1, 32'd0);

    // read before clear completes with old data; clear beats a simultaneous write
    set_wr(4'd5, 32'hDEADBEEF, 4'hF); tick();
    set_rd(4'd5); tick();
    check("pre_clr_v0", {31'd0, rd_valid0}, 32'd1);
    check("pre_clr_d0", data_out0, 32'hDEADBEEF);
    set_wr(4'd5, 32'h12345678, 4'hF);
    clear = 1'b1;
    tick();
    check("clr_busy0", {31'd0, busy0}, 32'd1);
    check("clr_v1", {31'd0, rd_valid1}, 32'd1);
    check("clr_d1", data_out1, 32'hDEADBEEF);
    check("clr_v0", {31'd0, rd_valid0}, 32'd0);
    // writes during busy must be dropped
    set_wr(4'd5, 32'hFFFFFFFF, 4'hF);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) idle();
      check($sformatf("clr_busy_k%0d", k), {31'd0, busy0}, (k < 16) ? 32'd1 : 32'd0);
    end
    set_rd(4'd5); tick();
    check("post_clr_a5_v0", {31'd0, rd_valid0}, 32'd1);
    check("post_clr_a5_d0", data_out0, 32'd0);
    set_rd(4'd3); tick();
    idle();
    check("post_clr_a3_d0", data_out0, 32'd0);
    tick();

    // reset in the middle of CLEAR restarts the full sweep
    clear = 1'b1; tick();
    idle();
    for (int k = 1; k <= 7; k++) tick();
    rst_n = 1'b0;
    #1;
    check("midclr_rst_busy", {31'd0, busy0}, 32'd1);
    tick();
    rst_n = 1'b1;
    check_sweep("midclr");

    // reset with reads in flight kills them
    set_wr(4'd9, 32'hCAFEF00D, 4'hF); tick();
    set_rd(4'd9); tick();
    idle();
    check("inflight_v0", {31'd0, rd_valid0}, 32'd1);
    check("inflight_d0", data_out0, 32'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    check("inflight_rst_v0", {31'd0, rd_valid0}, 32'd0);
    check("inflight_rst_d0", data_out0, 32'd0);
    tick();
    check("inflight_rst_v1", {31'd0, rd_valid1}, 32'd0);
    check("inflight_rst_d1", data_out1, 32'd0);
    rst_n = 1'b1;
    check_sweep("rerst");
    set_rd(4'd9); tick();
    idle();
    check("rerst_a9_d0", data_out0, 32'd0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8, from 8 upward.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter OUT_REG, default 0, 0 = read latency 1, 1 = extra output register (read latency 2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port CS  input  1  chip select, qualifies an access this cycle.
REQ-007 SHALL have port wr_en  input  1  1 = write, 0 = read when CS=1.
REQ-008 SHALL have port byte_en  input  DATA_WIDTH/8  per-byte write enable, bit i covers data_in[8i+7:8i].
REQ-009 SHALL have port addr_in  input  ADDR_WIDTH  word address.
REQ-010 SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-011 SHALL have port clear  input  1  single-cycle request to zero the whole array.
REQ-012 SHALL have port data_out  output  DATA_WIDTH  read data, valid only while rd_valid=1.
REQ-013 SHALL have port rd_valid  output  1  data_out carries the result of an accepted read.
REQ-014 SHALL have port busy  output  1  array is being zeroed, accesses not accepted.

Function
REQ-015 SHALL implement FSM states INIT, READY, CLEAR; INIT and CLEAR zero one word per cycle via a counter running 0..DEPTH-1.
REQ-016 SHALL in INIT/CLEAR write all-zero at counter address each edge; after the edge writing DEPTH-1, go to READY and return counter to 0.
REQ-017 SHALL drive busy=1 whenever state is INIT or CLEAR, i.e. exactly DEPTH cycles per zeroing pass.
REQ-018 SHALL accept an access only in READY with CS=1; when busy=1, CS/wr_en/clear are ignored and dropped, not queued.
REQ-019 SHALL on accepted write update only bytes with byte_en=1; byte_en=0 on all bits is a legal no-op write.
REQ-020 SHALL on accepted read capture memory[addr_in] at that edge; OUT_REG=0: rd_valid=1 and data valid in the following cycle; OUT_REG=1: one cycle later.
REQ-021 SHALL accept back-to-back reads every cycle, with rd_valid high for each, in issue order.
REQ-022 SHALL return the written data when a read follows a write to the same address on the next cycle.
REQ-023 SHALL drive data_out all-zero whenever rd_valid=0.
REQ-024 SHALL, in READY, when clear=1 go to CLEAR at that edge; if CS=1 in the same cycle, clear wins and the access is dropped.
REQ-025 SHALL let reads accepted before a clear complete normally with pre-clear data; the read pipeline is not flushed by clear.
REQ-026 SHALL ignore addr_in bits beyond DEPTH; none exist, since DEPTH is exactly 2**ADDR_WIDTH, so no wrap logic is needed.

Reset
REQ-027 SHALL on rst_n=0 asynchronously set state=INIT, counter=0, busy=1, rd_valid=0, data_out=0, and clear all read pipeline registers.
REQ-028 SHALL start zeroing at the first rising clk edge after rst_n rises; memory contents before INIT completes are undefined and never readable.
REQ-029 SHALL restart INIT from address 0 on reset asserted mid-INIT, mid-CLEAR or with a read in flight; no rd_valid pulse survives reset.

Verification
REQ-030 SHALL cover: DW=32, AW=4, OUT_REG=0, reset release -> busy=1 for 16 cycles, then 0; a read of any address -> 0x00000000.
REQ-031 SHALL cover: write addr 3 data 0xAABBCCDD byte_en=4'b1111, then write addr 3 data 0x11223344 byte_en=4'b0101, read addr 3 -> rd_valid next cycle, data_out=0xAA22CC44.
REQ-032 SHALL cover: reads of addr 0,1,2 on consecutive cycles (holding 0x10,0x20,0x30) with OUT_REG=1 -> rd_valid high 3 cycles starting 2 cycles after the first read, data 0x10,0x20,0x30; data_out=0 otherwise.
REQ-033 SHALL cover: clear=1 together with CS=1, wr_en=1, addr 5 -> write dropped, busy=1 for 16 cycles, addr 5 reads 0 afterward; writes during busy have no effect.
REQ-034 SHALL cover: rst_n pulsed low at CLEAR counter=7 -> busy stays 1, INIT restarts at 0, busy falls exactly 16 cycles after rst_n release.
REQ-035 SHALL cover: read accepted the cycle before clear -> rd_valid=1 with old data (e.g. 0xDEADBEEF) while busy=1.
